// File: rtl/tx_frame.sv
// tx_frame: serial frame transmitter.
// Buffers one {data, instr} frame through a valid/ready handshake and sends it
// as: one low start bit, data[3:0] MSB first, instr[3:0] MSB first, then
// GAP_BITS idle-high bit periods. Every bit period lasts BIT_CYCLES clk2 cycles.
module tx_frame #(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic       clk2,
    input  logic       reset,
    input  logic       send,
    input  logic [3:0] data_in,
    input  logic [3:0] instr_in,
    output logic       ready,
    output logic       transmission,
    output logic       busy,
    output logic       frame_done
);

    // Counter widths: at least 1 bit, and the bit counter covers both the
    // 8 payload bits and the guard gap.
    localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BMAX = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int BW   = $clog2(BMAX);

    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] SHIFT_LAST = BW'(7);
    localparam logic [BW-1:0] GAP_LAST   = BW'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic            buf_valid_q, buf_valid_d;
    logic [7:0]      buf_q, buf_d;
    logic [7:0]      shift_q, shift_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            line_q, line_d;
    logic            done_q, done_d;
    logic            bit_wrap;

    // A bit period ends on the cycle where the cycle counter reaches its last value.
    assign bit_wrap = (cyc_q == CYC_LAST);

    // State register; reset aborts any frame in flight and drops the buffer.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            shift_q     <= '0;
            cyc_q       <= '0;
            bit_q       <= '0;
            line_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            shift_q     <= shift_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            line_q      <= line_d;
            done_q      <= done_d;
        end
    end

    // Handshake buffer plus the serializer FSM; the line value is computed
    // one cycle ahead so the transmitted bit comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        shift_d     = shift_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        line_d      = line_q;
        done_d      = 1'b0;

        // Accept only into an empty buffer, so it can never collide with the
        // IDLE drain below, which needs the buffer full.
        if (send && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_d       = {data_in, instr_in};
        end

        unique case (state_q)
            IDLE: begin
                line_d = 1'b1;
                cyc_d  = '0;
                bit_d  = '0;
                if (buf_valid_q) begin
                    shift_d     = buf_q;
                    buf_valid_d = 1'b0;
                    state_d     = START;
                    line_d      = 1'b0;
                end
            end
            START: begin
                cyc_d = bit_wrap ? '0 : cyc_q + 1'b1;
                if (bit_wrap) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    line_d  = shift_q[7];
                end
            end
            SHIFT: begin
                cyc_d = bit_wrap ? '0 : cyc_q + 1'b1;
                if (bit_wrap) begin
                    if (bit_q == SHIFT_LAST) begin
                        state_d = GAP;
                        bit_d   = '0;
                        line_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[6:0], 1'b0};
                        line_d  = shift_q[6];
                    end
                end
            end
            GAP: begin
                cyc_d  = bit_wrap ? '0 : cyc_q + 1'b1;
                line_d = 1'b1;
                if (bit_wrap) begin
                    if (bit_q == GAP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    assign ready        = !buf_valid_q;
    assign busy         = (state_q != IDLE) || buf_valid_q;
    assign transmission = line_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_tx_frame.sv
// tb_tx_frame: scoreboard bench for tx_frame.
// Two instances: a fast one (BIT_CYCLES=1, GAP_BITS=2) and a slow one
// (BIT_CYCLES=3, GAP_BITS=1). Each accepted frame pushes its expected line
// waveform; a monitor per instance records the line and compares on frame_done.
module tb_tx_frame;

    logic       clk2;
    logic       reset;
    logic       sendA, sendB;
    logic [3:0] dataA, dataB, instrA, instrB;
    logic       readyA, readyB, lineA, lineB, busyA, busyB, doneA, doneB;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] expA[$];
    logic [30:0] expB[$];
    int          doneCyclesA[$];

    tx_frame #(.BIT_CYCLES(1), .GAP_BITS(2)) dutFast (
        .clk2(clk2), .reset(reset), .send(sendA), .data_in(dataA), .instr_in(instrA),
        .ready(readyA), .transmission(lineA), .busy(busyA), .frame_done(doneA)
    );

    tx_frame #(.BIT_CYCLES(3), .GAP_BITS(1)) dutSlow (
        .clk2(clk2), .reset(reset), .send(sendB), .data_in(dataB), .instr_in(instrB),
        .ready(readyB), .transmission(lineB), .busy(busyB), .frame_done(doneB)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Slow waveform: 10 bit periods of 3 samples each, then the idle sample
    // that coincides with frame_done.
    function automatic logic [30:0] expandSlow(input logic [3:0] d, input logic [3:0] i);
        logic [9:0]  bits;
        logic [30:0] r;
        bits = {1'b0, d, i, 1'b1};
        r = '0;
        for (int k = 9; k >= 0; k--) r = {r[27:0], {3{bits[k]}}};
        r = {r[29:0], 1'b1};
        return r;
    endfunction

    task automatic driveInputs(input bit slow, input logic s, input logic [3:0] d, input logic [3:0] i);
        if (slow) begin
            sendB = s; dataB = d; instrB = i;
        end else begin
            sendA = s; dataA = d; instrA = i;
        end
    endtask

    // Producer obeying the handshake: holds send until ready, optionally
    // changing data each blocked cycle; pushes the frame actually accepted.
    task automatic applyStimulus(input bit slow, input logic [3:0] d, input logic [3:0] i,
                                 input bit vary, output int waited);
        logic [3:0] curD;
        logic       rdy;
        waited = 0;
        curD   = d;
        @(negedge clk2);
        driveInputs(slow, 1'b1, curD, i);
        rdy = slow ? readyB : readyA;
        while (!rdy && waited < 200) begin
            @(negedge clk2);
            waited++;
            if (vary) curD = d + waited[3:0];
            driveInputs(slow, 1'b1, curD, i);
            rdy = slow ? readyB : readyA;
        end
        if (!rdy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL readyTimeout: got ready=0, expected ready=1 within 200 cycles");
        end else if (slow) begin
            expB.push_back(expandSlow(curD, i));
        end else begin
            expA.push_back({1'b0, curD, i, 3'b111});
        end
        @(posedge clk2);
        #1;
        driveInputs(slow, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic waitDoneA();
        int n = 0;
        do begin
            @(negedge clk2);
            n++;
        end while (doneA !== 1'b1 && n < 50);
        if (doneA !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL doneTimeout: got frame_done=0, expected a pulse within 50 cycles");
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk2);
            n++;
        end while ((busyA !== 1'b0 || busyB !== 1'b0) && n < 300);
        if (busyA !== 1'b0 || busyB !== 1'b0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idleTimeout: got busy=%b/%b, expected 0/0 within 300 cycles", busyA, busyB);
        end
        repeat (2) @(negedge clk2);
    endtask

    // Fast monitor: 12-sample history = start, 8 payload bits, 2 gap bits, idle.
    initial begin : monitorFast
        logic [11:0] hist;
        int          cyc;
        hist = '1;
        cyc  = 0;
        forever begin
            @(negedge clk2);
            cyc++;
            hist = {hist[10:0], lineA};
            if (doneA === 1'b1) begin
                doneCyclesA.push_back(cyc);
                if (expA.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL frameFast: got unexpected frame 0x%0h, expected none", hist);
                end else begin
                    checkOutput("frameFast", 32'(hist), 32'(expA.pop_front()));
                end
            end
        end
    end

    // Slow monitor: 31-sample history covering the whole 30-cycle frame.
    initial begin : monitorSlow
        logic [30:0] hist;
        hist = '1;
        forever begin
            @(negedge clk2);
            hist = {hist[29:0], lineB};
            if (doneB === 1'b1) begin
                if (expB.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL frameSlow: got unexpected frame 0x%0h, expected none", hist);
                end else begin
                    checkOutput("frameSlow", 32'(hist), 32'(expB.pop_front()));
                end
            end
        end
    end

    initial begin : stimulus
        int w;
        reset = 1'b1;
        driveInputs(1'b0, 1'b0, 4'h0, 4'h0);
        driveInputs(1'b1, 1'b0, 4'h0, 4'h0);

        // Reset values before any clock edge.
        #1;
        checkOutput("resetLine",  32'(lineA),  32'(1));
        checkOutput("resetReady", 32'(readyA), 32'(1));
        checkOutput("resetBusy",  32'(busyA),  32'(0));
        checkOutput("resetDone",  32'(doneA),  32'(0));
        checkOutput("resetLineSlow", 32'(lineB), 32'(1));
        #11 reset = 1'b0;
        repeat (2) @(negedge clk2);

        // Single frame A/4: line 0,1010,0100,1,1.
        applyStimulus(1'b0, 4'hA, 4'h4, 1'b0, w);
        checkOutput("bufferedBusy",  32'(busyA),  32'(1));
        checkOutput("bufferedReady", 32'(readyA), 32'(0));
        waitDoneA();
        checkOutput("doneBusy",  32'(busyA),  32'(0));
        checkOutput("doneReady", 32'(readyA), 32'(1));
        checkOutput("doneLine",  32'(lineA),  32'(1));
        waitIdle();

        // Back-to-back 3/1 then F/4, then a backpressured frame whose data
        // changes every blocked cycle: accepted value is 0 + 11 = B.
        doneCyclesA.delete();
        applyStimulus(1'b0, 4'h3, 4'h1, 1'b0, w);
        applyStimulus(1'b0, 4'hF, 4'h4, 1'b0, w);
        checkOutput("b2bWait", 32'(w), 32'(1));
        applyStimulus(1'b0, 4'h0, 4'h4, 1'b1, w);
        checkOutput("backpressureWait", 32'(w), 32'(11));
        waitIdle();
        checkOutput("b2bDoneCount", 32'(doneCyclesA.size()), 32'(3));
        if (doneCyclesA.size() >= 3) begin
            checkOutput("b2bSpacing1", 32'(doneCyclesA[1] - doneCyclesA[0]), 32'(12));
            checkOutput("b2bSpacing2", 32'(doneCyclesA[2] - doneCyclesA[1]), 32'(12));
        end

        // Reset during instruction bit i2 (0 for instr 1) with a frame buffered.
        applyStimulus(1'b0, 4'hC, 4'h1, 1'b0, w);
        applyStimulus(1'b0, 4'h6, 4'h4, 1'b0, w);
        repeat (6) @(negedge clk2);
        checkOutput("midFrameLine", 32'(lineA), 32'(0));
        #1 reset = 1'b1;
        expA.delete();
        #1;
        checkOutput("abortLine",  32'(lineA),  32'(1));
        checkOutput("abortReady", 32'(readyA), 32'(1));
        checkOutput("abortBusy",  32'(busyA),  32'(0));
        checkOutput("abortDone",  32'(doneA),  32'(0));
        @(negedge clk2);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk2);
        applyStimulus(1'b0, 4'h5, 4'h2, 1'b0, w);
        waitIdle();

        // Slow instance: 5/1, every bit held 3 cycles, 30 cycles to frame_done.
        applyStimulus(1'b1, 4'h5, 4'h1, 1'b0, w);
        waitIdle();

        checkOutput("leftoverFast", 32'(expA.size()), 32'(0));
        checkOutput("leftoverSlow", 32'(expB.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
